// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the TDM sample link. Tracks slot position,
// steers each accepted sample to its channel register with a one-cycle
// strobe, flags framing errors and re-locks on the next frame sync.
module tdm_demux #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   localparam int unsigned SW   = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       din,
   input  logic                   din_valid,
   input  logic                   frame_sync,
   output logic [NCH*WIDTH-1:0]   ch_data,
   output logic [NCH-1:0]         ch_valid,
   output logic                   frame_done,
   output logic                   sync_err,
   output logic                   locked,
   output logic [SW-1:0]          slot
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

   state_t          state;
   state_t          state_n;
   logic [SW-1:0]   slot_n;
   logic            wr_en;
   logic [SW-1:0]   wr_ch;
   logic            done_n;
   logic            err_n;

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         slot       <= '0;
         ch_data    <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_n;
         slot       <= slot_n;
         ch_valid   <= wr_en ? (NCH'(1) << wr_ch) : NCH'(0);
         frame_done <= done_n;
         sync_err   <= err_n;
         locked     <= (state_n == LOCKED);
         for (int unsigned k = 0; k < NCH; k++) begin
            if (wr_en && (wr_ch == SW'(k))) begin
               ch_data[k*WIDTH +: WIDTH] <= din;
            end
         end
      end
   end

   // Next-state, slot tracking and write/strobe decisions
   always_comb begin
      state_n = state;
      slot_n  = slot;
      wr_en   = 1'b0;
      wr_ch   = '0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               // Unsynced samples are dropped silently while hunting
               if (frame_sync) begin
                  wr_en   = 1'b1;
                  wr_ch   = '0;
                  slot_n  = SW'(1);
                  state_n = LOCKED;
               end
            end
            LOCKED: begin
               if (slot == '0) begin
                  if (frame_sync) begin
                     wr_en  = 1'b1;
                     wr_ch  = '0;
                     slot_n = SW'(1);
                  end else begin
                     // Missing sync: lose lock and drop the sample
                     err_n   = 1'b1;
                     slot_n  = '0;
                     state_n = HUNT;
                  end
               end else if (frame_sync) begin
                  // Early sync: abandon the partial frame, restart at slot 0
                  err_n  = 1'b1;
                  wr_en  = 1'b1;
                  wr_ch  = '0;
                  slot_n = SW'(1);
               end else begin
                  wr_en = 1'b1;
                  wr_ch = slot;
                  if (slot == LAST_SLOT) begin
                     done_n = 1'b1;
                     slot_n = '0;
                  end else begin
                     slot_n = slot + SW'(1);
                  end
               end
            end
            default: begin
               state_n = HUNT;
               slot_n  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux (WIDTH=8, NCH=4).
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        frame_sync;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic        frame_done;
   logic        sync_err;
   logic        locked;
   logic [1:0]  slot;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_data;

   tdm_demux #(.WIDTH(8), .NCH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .locked     (locked),
      .slot       (slot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] cv, input logic done,
                            input logic err, input logic lck, input logic [1:0] sl);
      chk({tag, ".ch_data"},    ch_data,           exp_data);
      chk({tag, ".ch_valid"},   32'(ch_valid),     32'(cv));
      chk({tag, ".frame_done"}, 32'(frame_done),   32'(done));
      chk({tag, ".sync_err"},   32'(sync_err),     32'(err));
      chk({tag, ".locked"},     32'(locked),       32'(lck));
      chk({tag, ".slot"},       32'(slot),         32'(sl));
   endtask

   // One clock with given inputs, then check outputs #1 after the edge
   task automatic step(input string tag, input logic v, input logic [7:0] d, input logic s,
                       input logic [3:0] cv, input logic done, input logic err,
                       input logic lck, input logic [1:0] sl);
      @(negedge clk);
      din_valid  = v;
      din        = d;
      frame_sync = s;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (cv[k]) exp_data[k*8 +: 8] = d;
      end
      check_all(tag, cv, done, err, lck, sl);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst        = 1'b1;
      din_valid  = 1'b0;
      din        = 8'hFF;
      frame_sync = 1'b1;
      @(posedge clk);
      #1;
      exp_data = '0;
      check_all(tag, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst        = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic idle3(input string tag, input logic s_mid, input logic lck, input logic [1:0] sl);
      step({tag, ".i0"}, 1'b0, 8'hEE, 1'b0,  4'b0000, 1'b0, 1'b0, lck, sl);
      step({tag, ".i1"}, 1'b0, 8'hEE, s_mid, 4'b0000, 1'b0, 1'b0, lck, sl);
      step({tag, ".i2"}, 1'b0, 8'hEE, 1'b0,  4'b0000, 1'b0, 1'b0, lck, sl);
   endtask

   initial begin
      rst = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
      exp_data = '0;

      // 1: two back-to-back frames
      do_reset("s1.rst");
      step("s1.b1", 1'b1, 8'h10, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      step("s1.b2", 1'b1, 8'h11, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      step("s1.b3", 1'b1, 8'h12, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      step("s1.b4", 1'b1, 8'h13, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
      chk("s1.frame1", ch_data, 32'h13121110);
      step("s1.b5", 1'b1, 8'h20, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      step("s1.b6", 1'b1, 8'h21, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      step("s1.b7", 1'b1, 8'h22, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      step("s1.b8", 1'b1, 8'h23, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
      chk("s1.final", ch_data, 32'h23222120);

      // 2: hunting discards unsynced samples
      do_reset("s2.rst");
      step("s2.b1", 1'b1, 8'hAA, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      step("s2.b2", 1'b1, 8'hBB, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      step("s2.b3", 1'b1, 8'h01, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      chk("s2.data", ch_data, 32'h00000001);

      // 3: early sync restarts frame at slot 0
      do_reset("s3.rst");
      step("s3.b1", 1'b1, 8'h30, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      step("s3.b2", 1'b1, 8'h31, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      step("s3.b3", 1'b1, 8'h40, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd1);
      chk("s3.data", ch_data, 32'h00003140);

      // 4: finish frame, then missing sync drops lock
      step("s4.b1", 1'b1, 8'h41, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      step("s4.b2", 1'b1, 8'h42, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      step("s4.b3", 1'b1, 8'h43, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
      step("s4.miss", 1'b1, 8'h55, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
      chk("s4.data", ch_data, 32'h43424140);
      step("s4.hunt", 1'b1, 8'h56, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);

      // 5: idle gaps, including a sync during idle
      do_reset("s5.rst");
      idle3("s5.g0", 1'b1, 1'b0, 2'd0);
      step("s5.b1", 1'b1, 8'h10, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      idle3("s5.g1", 1'b1, 1'b1, 2'd1);
      step("s5.b2", 1'b1, 8'h11, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      idle3("s5.g2", 1'b0, 1'b1, 2'd2);
      step("s5.b3", 1'b1, 8'h12, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      idle3("s5.g3", 1'b0, 1'b1, 2'd3);
      step("s5.b4", 1'b1, 8'h13, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
      idle3("s5.g4", 1'b1, 1'b1, 2'd0);
      step("s5.b5", 1'b1, 8'h20, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      idle3("s5.g5", 1'b0, 1'b1, 2'd1);
      step("s5.b6", 1'b1, 8'h21, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      idle3("s5.g6", 1'b1, 1'b1, 2'd2);
      step("s5.b7", 1'b1, 8'h22, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      idle3("s5.g7", 1'b0, 1'b1, 2'd3);
      step("s5.b8", 1'b1, 8'h23, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
      chk("s5.final", ch_data, 32'h23222120);

      // 6: mid-frame reset discards partial frame
      do_reset("s6.rst0");
      step("s6.b1", 1'b1, 8'h10, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      step("s6.b2", 1'b1, 8'h11, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      step("s6.b3", 1'b1, 8'h12, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
      do_reset("s6.rst1");
      step("s6.nosync", 1'b1, 8'h77, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      step("s6.sync",   1'b1, 8'h77, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
      chk("s6.data", ch_data, 32'h00000077);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's time-division-multiplexed sample link. The transmit side muxes N channels onto one bus, one sample per valid beat, and marks channel 0 with frame_sync.
- This block tracks the slot position and steers each sample back to its own channel register with a one-cycle valid strobe.
- It flags framing errors and re-locks on the next sync.

Parameters:
WIDTH, 8, bits per sample
NCH, 4, channels per frame (2..16)
SW, $clog2(NCH), slot counter width (derived, localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  WIDTH  multiplexed sample
din_valid  input  1  din carries a sample this cycle
frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0
ch_data  output  NCH*WIDTH  channel registers; channel k at bits [k*WIDTH +: WIDTH]
ch_valid  output  NCH  one-hot, one-cycle pulse: channel k updated this cycle
frame_done  output  1  one-cycle pulse when slot NCH-1 is written
sync_err  output  1  one-cycle pulse on framing error
locked  output  1  high in LOCKED state
slot  output  SW  slot the next accepted sample will occupy

Behaviour:
- Reset: applied on clk edge while rst=1. Takes priority over all inputs. Mid-frame reset discards the partial frame.
- Values after reset: ch_data=0, ch_valid=0, frame_done=0, sync_err=0, locked=0, slot=0, state=HUNT.
- All outputs are registered. The sample accepted at edge n appears on ch_data, with its ch_valid bit, after edge n (latency 1).
- ch_data holds its value between updates. Only the addressed channel changes.
- Accepted beat: din_valid=1. Beats with din_valid=0 change nothing, and all pulses return to 0.
- State HUNT:
  - valid and frame_sync: write channel 0, slot<=1, go to LOCKED.
  - valid without sync: discard, no strobe, no error, slot stays 0.
- State LOCKED, on a valid beat:
  - slot=0 and frame_sync=1: write channel 0, slot<=1.
  - slot=0 and frame_sync=0 (missing sync): discard sample, sync_err=1, go to HUNT, slot<=0.
  - slot!=0 and frame_sync=0: write channel slot, slot<=slot+1.
  - slot!=0 and frame_sync=1 (early sync): sync_err=1; treat the sample as slot 0 of a new frame (write channel 0, slot<=1), stay LOCKED. The partial frame's written channels keep their values. No frame_done is issued for the partial frame.
- Wrap: the write to slot NCH-1 sets frame_done=1 and slot<=0. slot never exceeds NCH-1.
- If NCH is not a power of 2, the counter wraps explicitly at NCH-1, not by overflow.
- locked=1 exactly when state=LOCKED.
- ch_valid is all-zero on any cycle where no sample is written, including discards and HUNT.
- Strobe count: at most one ch_valid bit set per cycle. frame_done and sync_err can never both be 1 in the same cycle.

Test Plan:
1. Reset, then 8 consecutive valid beats din=0x10,0x11,0x12,0x13,0x20,0x21,0x22,0x23, with sync on beats 1 and 5:
   - ch_valid sequence 0001,0010,0100,1000 twice.
   - frame_done on the 4th and 8th output cycles.
   - Final ch_data = {0x23,0x22,0x21,0x20}, sync_err never 1.
2. After reset, valid beats 0xAA,0xBB without sync, then 0x01 with sync:
   - No strobes and locked=0 for the first two beats.
   - After the third: ch_data[7:0]=0x01, ch_valid=0001, locked=1, slot=1.
3. Locked. Send 0x30 (sync), 0x31, then 0x40 with sync (early sync):
   - sync_err=1 together with ch_valid=0001.
   - ch_data[7:0]=0x40, ch_data[15:8]=0x31, slot=1, locked=1.
4. Complete a frame, then send 0x55 without sync:
   - sync_err=1, ch_valid=0000, locked=0, slot=0.
   - ch_data unchanged.
5. Insert din_valid=0 gaps (e.g. 3 idle cycles) between every sample of a frame, with frame_sync=1 asserted during one idle cycle:
   - Identical channel results to scenario 1.
   - Idle-cycle sync ignored, no sync_err.
6. Assert rst for one cycle after slot 2 is written:
   - All outputs zero next cycle, locked=0.
   - A subsequent 0x77 without sync is discarded.
   - 0x77 with sync lands in channel 0.
